axi_burst_master: RTL and testbench

- AXI4 initiator (master) that drives transactions into axi_slave.
- Accepts one command at a time (read or write, INCR burst) from a simple valid/ready command port.
- Streams write data in and read data out, and reports the final response.
- Used as the stimulus-side RTL counterpart of the slave in system-level and VIP cross-checks.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_burst_master_if.sv | 68 ++++++
 rtl/axi_burst_master.sv | 166 ++++++++++++++++
 tb/tb_axi_burst_master.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master: burst/response encodings,
// the controller state enum and the AxSIZE helper.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_t;

    // AxSIZE encoding for a power-of-two beat size in bytes.
    function automatic logic [2:0] size_log2(input int unsigned bytes);
        logic [2:0] result;
        result = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) begin
                result = i[2:0];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle between the burst master and a slave.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one command in, one AW/AR burst
// out, write beats streamed in, read beats streamed out, one completion pulse.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int FIXED_ID = 0
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,

    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,

    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,

    output logic                done_valid,
    output logic [1:0]          done_resp,

    axi_burst_master_if.master  bus
);

    localparam logic [2:0] BEAT_SIZE = size_log2(DATA_W / 8);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        count_q, count_d;
    logic [1:0]        worst_resp_q, worst_resp_d;
    logic              done_valid_q, done_valid_d;
    logic [1:0]        done_resp_q, done_resp_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            worst_resp_q <= RESP_OKAY;
            done_valid_q <= 1'b0;
            done_resp_q  <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            count_q      <= count_d;
            worst_resp_q <= worst_resp_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        count_d      = count_q;
        worst_resp_d = worst_resp_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d       = cmd_addr;
                    len_d        = cmd_len;
                    count_d      = '0;
                    worst_resp_d = RESP_OKAY;
                    state_d      = cmd_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (bus.awready) begin
                    count_d = '0;
                    state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (wr_valid && bus.wready) begin
                    count_d = count_q + 8'd1;
                    if (count_q == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (bus.bvalid) begin
                    done_valid_d = 1'b1;
                    done_resp_d  = bus.bresp;
                    state_d      = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (bus.arready) begin
                    count_d = '0;
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Burst ends on RLAST alone; the beat count is informational only.
                if (bus.rvalid && rd_ready) begin
                    count_d      = count_q + 8'd1;
                    worst_resp_d = (bus.rresp > worst_resp_q) ? bus.rresp : worst_resp_q;
                    if (bus.rlast) begin
                        done_valid_d = 1'b1;
                        done_resp_d  = worst_resp_d;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding off during the completion pulse makes the next command land one cycle after it.
    assign cmd_ready   = (state_q == ST_IDLE) && !done_valid_q;

    assign bus.awid    = ID_W'(FIXED_ID);
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = len_q;
    assign bus.awsize  = BEAT_SIZE;
    assign bus.awburst = BURST_INCR;
    assign bus.awvalid = (state_q == ST_WADDR);

    assign bus.wdata   = wr_data;
    assign bus.wstrb   = wr_strb;
    assign bus.wlast   = (count_q == len_q);
    assign bus.wvalid  = (state_q == ST_WDATA) && wr_valid;
    assign wr_ready    = (state_q == ST_WDATA) && bus.wready;

    assign bus.bready  = (state_q == ST_WRESP);

    assign bus.arid    = ID_W'(FIXED_ID);
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len_q;
    assign bus.arsize  = BEAT_SIZE;
    assign bus.arburst = BURST_INCR;
    assign bus.arvalid = (state_q == ST_RADDR);

    assign bus.rready  = (state_q == ST_RDATA) && rd_ready;
    assign rd_valid    = (state_q == ST_RDATA) && bus.rvalid;
    assign rd_data     = bus.rdata;
    assign rd_last     = (state_q == ST_RDATA) && bus.rlast;

    assign done_valid  = done_valid_q;
    assign done_resp   = done_resp_q;

    logic unused_ids;
    assign unused_ids = ^{bus.bid, bus.rid};

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: the bench plays the AXI slave and
// the command/stream user, predicting every beat and response from the burst rules.
module tb_axi_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        done_valid;
    logic [1:0]  done_resp;

    int checks   = 0;
    int failures = 0;

    axi_burst_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi_bus ();

    axi_burst_master #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .FIXED_ID(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .done_valid (done_valid),
        .done_resp  (done_resp),
        .bus        (axi_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic abort_run(input string what);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got no progress, required completion within bound", what);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic slave_idle();
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.bid     = '0;
        axi_bus.bresp   = 2'd0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.arready = 1'b0;
        axi_bus.rid     = '0;
        axi_bus.rdata   = '0;
        axi_bus.rresp   = 2'd0;
        axi_bus.rlast   = 1'b0;
        axi_bus.rvalid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        axi_bus.awready = 1'b1;
        axi_bus.wready  = 1'b1;
        axi_bus.bvalid  = 1'b1;
        axi_bus.arready = 1'b1;
        axi_bus.rvalid  = 1'b1;
        axi_bus.rlast   = 1'b1;
        repeat (2) tick();
        #1;
        checks++;
        if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_valids: got %b required 00000",
                     {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready});
        end
        checks++;
        if ({done_valid, done_resp, rd_valid, cmd_ready} !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL reset_status: got %b required 00001", {done_valid, done_resp, rd_valid, cmd_ready});
        end
        checks++;
        if ({axi_bus.awaddr, axi_bus.awlen} !== 40'h0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got %h required 0", {axi_bus.awaddr, axi_bus.awlen});
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        slave_idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write(input logic [31:0] addr, input int len, input int aw_delay,
                              input bit rand_hs, input bit seq_data, input logic [1:0] bresp_v);
        logic [31:0] data_q[$];
        logic [3:0]  strb_q[$];
        int n;
        int i;
        int cyc;
        int aw_cnt;
        int bdly;
        for (int k = 0; k <= len; k++) begin
            data_q.push_back(seq_data ? 32'hA0 + k : $urandom);
            strb_q.push_back(seq_data ? 4'hF : 4'($urandom));
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        #1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) abort_run("write_cmd");
        checks++;
        if (axi_bus.awvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL aw_early: got %b required 0", axi_bus.awvalid);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_len   = 8'($urandom);

        aw_cnt = 0;
        for (int c = 0; c <= aw_delay; c++) begin
            axi_bus.awready = (c == aw_delay);
            #1;
            if (axi_bus.awvalid === 1'b1) aw_cnt++;
            checks++;
            if ({axi_bus.awvalid, axi_bus.awaddr, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst, axi_bus.awid}
                !== {1'b1, addr, 8'(len), 3'd2, 2'b01, 4'd0}) begin
                failures++;
                $display("[TB] FAIL aw_fields: got %h required %h",
                         {axi_bus.awvalid, axi_bus.awaddr, axi_bus.awlen, axi_bus.awsize, axi_bus.awburst, axi_bus.awid},
                         {1'b1, addr, 8'(len), 3'd2, 2'b01, 4'd0});
            end
            tick();
        end
        axi_bus.awready = 1'b0;
        checks++;
        if (aw_cnt != aw_delay + 1) begin
            failures++;
            $display("[TB] FAIL aw_hold: got %0d cycles required %0d", aw_cnt, aw_delay + 1);
        end

        i = 0;
        cyc = 0;
        while (i <= len) begin
            if (cyc > 500) abort_run("write_data");
            wr_valid = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi_bus.wready = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data = data_q[i];
            wr_strb = strb_q[i];
            #1;
            checks++;
            if ({axi_bus.wvalid, wr_ready, axi_bus.awvalid} !== {wr_valid, axi_bus.wready, 1'b0}) begin
                failures++;
                $display("[TB] FAIL w_handshake: got %b required %b",
                         {axi_bus.wvalid, wr_ready, axi_bus.awvalid}, {wr_valid, axi_bus.wready, 1'b0});
            end
            if (wr_valid) begin
                checks++;
                if ({axi_bus.wdata, axi_bus.wstrb, axi_bus.wlast} !== {data_q[i], strb_q[i], 1'(i == len)}) begin
                    failures++;
                    $display("[TB] FAIL w_beat%0d: got %h required %h", i,
                             {axi_bus.wdata, axi_bus.wstrb, axi_bus.wlast}, {data_q[i], strb_q[i], 1'(i == len)});
                end
            end
            if (wr_valid && axi_bus.wready) i++;
            cyc++;
            tick();
        end
        wr_valid = 1'b0;
        axi_bus.wready = 1'b0;

        bdly = $urandom_range(0, 2);
        for (int d = 0; d < bdly; d++) begin
            #1;
            checks++;
            if ({axi_bus.bready, done_valid, cmd_ready} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL b_wait: got %b required 100", {axi_bus.bready, done_valid, cmd_ready});
            end
            tick();
        end
        axi_bus.bvalid = 1'b1;
        axi_bus.bresp  = bresp_v;
        axi_bus.bid    = 4'($urandom);
        #1;
        checks++;
        if (axi_bus.bready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b_ready: got %b required 1", axi_bus.bready);
        end
        tick();
        axi_bus.bvalid = 1'b0;
        #1;
        checks++;
        if ({done_valid, done_resp, cmd_ready} !== {1'b1, bresp_v, 1'b0}) begin
            failures++;
            $display("[TB] FAIL write_done: got %b required %b", {done_valid, done_resp, cmd_ready}, {1'b1, bresp_v, 1'b0});
        end
        tick();
        checks++;
        if (done_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_done_pulse: got %b required 0", done_valid);
        end
    endtask

    task automatic test_read(input logic [31:0] addr, input int len, input int mode,
                             input int err_idx, input bit b2b);
        logic [31:0] data_q[$];
        logic [1:0]  resp_q[$];
        logic [1:0]  r;
        logic [1:0]  exp_worst;
        int n;
        int i;
        int cyc;
        int ar_dly;
        exp_worst = 2'd0;
        for (int k = 0; k <= len; k++) begin
            data_q.push_back($urandom);
            if (err_idx == -2) r = 2'($urandom);
            else               r = (k == err_idx) ? 2'd2 : 2'd0;
            resp_q.push_back(r);
            if (r > exp_worst) exp_worst = r;
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        #1;
        if (b2b) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_cmd_ready: got %b required 1", cmd_ready);
            end
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) abort_run("read_cmd");
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;

        ar_dly = $urandom_range(0, 2);
        for (int c = 0; c <= ar_dly; c++) begin
            axi_bus.arready = (c == ar_dly);
            #1;
            checks++;
            if ({axi_bus.arvalid, axi_bus.awvalid, axi_bus.araddr, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst, axi_bus.arid}
                !== {2'b10, addr, 8'(len), 3'd2, 2'b01, 4'd0}) begin
                failures++;
                $display("[TB] FAIL ar_fields: got %h required %h",
                         {axi_bus.arvalid, axi_bus.awvalid, axi_bus.araddr, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst, axi_bus.arid},
                         {2'b10, addr, 8'(len), 3'd2, 2'b01, 4'd0});
            end
            tick();
        end
        axi_bus.arready = 1'b0;

        i = 0;
        cyc = 0;
        while (i <= len) begin
            if (cyc > 500) abort_run("read_data");
            rd_ready       = (mode == 0) ? ((cyc % 2) == 1) : ($urandom_range(0, 2) != 0);
            axi_bus.rvalid = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            axi_bus.rdata  = data_q[i];
            axi_bus.rresp  = resp_q[i];
            axi_bus.rlast  = (i == len);
            axi_bus.rid    = 4'($urandom);
            #1;
            checks++;
            if ({axi_bus.rready, rd_valid, done_valid, axi_bus.arvalid} !== {rd_ready, axi_bus.rvalid, 2'b00}) begin
                failures++;
                $display("[TB] FAIL r_handshake: got %b required %b",
                         {axi_bus.rready, rd_valid, done_valid, axi_bus.arvalid}, {rd_ready, axi_bus.rvalid, 2'b00});
            end
            if (axi_bus.rvalid) begin
                checks++;
                if ({rd_data, rd_last} !== {data_q[i], 1'(i == len)}) begin
                    failures++;
                    $display("[TB] FAIL r_beat%0d: got %h required %h", i, {rd_data, rd_last}, {data_q[i], 1'(i == len)});
                end
            end
            if (axi_bus.rvalid && rd_ready) i++;
            cyc++;
            tick();
        end
        axi_bus.rvalid = 1'b0;
        axi_bus.rlast  = 1'b0;
        rd_ready = 1'b0;
        #1;
        checks++;
        if ({done_valid, done_resp, cmd_ready} !== {1'b1, exp_worst, 1'b0}) begin
            failures++;
            $display("[TB] FAIL read_done: got %b required %b", {done_valid, done_resp, cmd_ready}, {1'b1, exp_worst, 1'b0});
        end
        tick();
        checks++;
        if (done_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_done_pulse: got %b required 0", done_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h500;
        cmd_len   = 8'd3;
        #1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (cmd_ready !== 1'b1) abort_run("reset_mid_cmd");
        tick();
        cmd_valid = 1'b0;
        axi_bus.awready = 1'b1;
        tick();
        axi_bus.awready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = $urandom;
        wr_strb  = 4'hF;
        axi_bus.wready = 1'b1;
        tick();
        axi_bus.wready = 1'b0;
        wr_data = $urandom;
        #1;
        checks++;
        if (axi_bus.wvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_beat2: got %b required 1", axi_bus.wvalid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({axi_bus.wvalid, axi_bus.awvalid, axi_bus.arvalid, axi_bus.bready, wr_ready, done_valid} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_async: got %b required 000000",
                     {axi_bus.wvalid, axi_bus.awvalid, axi_bus.arvalid, axi_bus.bready, wr_ready, done_valid});
        end
        tick();
        tick();
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_ready: got %b required 1", cmd_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (done_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_done: got %b required 0", done_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_write($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4), 0, 1'b1, 1'b0, 2'($urandom));
        test_read($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4), 1, -2, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            if ($urandom_range(0, 1) == 1)
                test_write($urandom & 32'hFFFF_FFFC, $urandom_range(0, 6), $urandom_range(0, 3),
                           1'b1, 1'b0, 2'($urandom));
            else
                test_read($urandom & 32'hFFFF_FFFC, $urandom_range(0, 6), 1, -2, 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_strb   = '0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        slave_idle();
        #1;
        test_reset();
        test_write(32'h100, 3, 0, 1'b0, 1'b1, 2'd0);
        test_read(32'h200, 7, 0, -1, 1'b0);
        test_read(32'h300, 2, 1, 1, 1'b0);
        test_write(32'h400, 0, 5, 1'b0, 1'b0, 2'd0);
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
